// File: rtl/contador_rst_pkg.sv
// Shared helpers for the modulo-N counter: parameter legality check used at
// elaboration time by contador_rst.
package contador_rst_pkg;

   // A modulus is legal when the count 0..N-1 fits in W bits and has at least two states.
   function automatic bit modulus_ok(input int n, input int w);
      return (n >= 2) && (longint'(n) <= (longint'(1) << w));
   endfunction

endpackage

// File: rtl/contador_rst.sv
// Modulo-N up-counter with synchronous enable and asynchronous active-low reset.
// Counts SCL rising edges inside an I2C byte frame in the slave models.
module contador_rst
   import contador_rst_pkg::*;
#(
   parameter int N = 9,
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         En,
   output logic [W-1:0] Out,
   output logic         Tc
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   generate
      if (!modulus_ok(N, W)) begin : g_bad_modulus
         $error("contador_rst: N=%0d is not representable as a modulus in W=%0d bits", N, W);
      end
   endgenerate

   logic [W-1:0] count_next;

   // Anything not strictly below the terminal value (including X or an illegal
   // value >= N) falls into the else branch and reloads zero.
   always_comb begin
      count_next = '0;
      if (Out < LAST) begin
         count_next = Out + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Out <= '0;
      end else if (En) begin
         Out <= count_next;
      end
   end

   assign Tc = (Out == LAST);

endmodule

// File: tb/tb_contador_rst.sv
// Scoreboard bench for contador_rst: directed stimulus pushes hand-computed
// expectations, a monitor pops and compares them against N=9 and N=4 instances.
module tb_contador_rst;

   logic       clk;
   logic       rst;
   logic       en;
   logic       en4;
   logic [3:0] out9;
   logic       tc9;
   logic [1:0] out4;
   logic       tc4;

   typedef struct {
      int    dut_id;
      int    out;
      bit    tc;
      string name;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   check_cnt = 0;
   int   fail_cnt  = 0;

   contador_rst #(.N(9), .W(4)) dut9 (
      .Clk (clk),
      .Rst (rst),
      .En  (en),
      .Out (out9),
      .Tc  (tc9)
   );

   contador_rst #(.N(4), .W(2)) dut4 (
      .Clk (clk),
      .Rst (rst),
      .En  (en4),
      .Out (out4),
      .Tc  (tc4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor drains every expectation posted since the last sample request.
   initial begin
      forever begin
         @(sample_ev);
         while (exp_q.size() > 0) begin
            exp_t e;
            int   act_out;
            bit   act_tc;
            e = exp_q.pop_front();
            if (e.dut_id == 9) begin
               act_out = int'(out9);
               act_tc  = tc9;
            end else begin
               act_out = int'(out4);
               act_tc  = tc4;
            end
            check_cnt++;
            if (act_out != e.out || act_tc != e.tc) begin
               fail_cnt++;
               $display("[TB] FAIL %s (N=%0d): got out=%0d tc=%0b, expected out=%0d tc=%0b",
                        e.name, e.dut_id, act_out, act_tc, e.out, e.tc);
            end
         end
      end
   end

   task automatic checkOutput(input int dut_id, input int out, input bit tc, input string name);
      exp_t e;
      e.dut_id = dut_id;
      e.out    = out;
      e.tc     = tc;
      e.name   = name;
      exp_q.push_back(e);
      -> sample_ev;
      #1;
   endtask

   // Drive controls, then advance past one rising edge so outputs have settled.
   task automatic applyStimulus(input logic r, input logic e9, input logic e4);
      rst = r;
      en  = e9;
      en4 = e4;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      en4 = 1'b0;
      #1;
      checkOutput(9, 0, 1'b0, "reset_async_initial");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput(9, 0, 1'b0, "reset_held_edge");
      checkOutput(4, 0, 1'b0, "reset_held_edge");

      // Count up to 5, then assert reset between edges.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput(9, i, 1'b0, "count_to_5");
      end
      rst = 1'b0;
      #1;
      checkOutput(9, 0, 1'b0, "async_reset_midcount");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput(9, 0, 1'b0, "reset_hold_3_edges");
      end

      // Release, count to terminal, wrap, then one more.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput(9, i, (i == 8), "count_terminal");
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(9, 0, 1'b0, "wrap_to_0");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(9, 1, 1'b0, "after_wrap");

      // Hold at 3 for four edges, then resume.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(9, 2, 1'b0, "to_hold_2");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(9, 3, 1'b0, "to_hold_3");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput(9, 3, 1'b0, "hold_en_low");
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(9, 4, 1'b0, "resume_after_hold");

      // Edge while reset is low must be ignored; first edge after release counts once.
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput(9, 0, 1'b0, "edge_during_reset");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(9, 1, 1'b0, "first_edge_after_release");

      // N=4 variant: reset both, then run the small counter alone.
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(4, 0, 1'b0, "n4_reset");
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkOutput(4, i % 4, ((i % 4) == 3), "n4_sequence");
      end
      checkOutput(9, 0, 1'b0, "n9_idle_while_n4_runs");

      // Bounded drain of any expectations the monitor has not reached.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         -> sample_ev;
         #1;
      end
      if (exp_q.size() > 0) begin
         fail_cnt++;
         $display("[TB] FAIL scoreboard_drain: pending=%0d, expected pending=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
      $finish;
   end

endmodule
